// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts MIPS-style instruction commands, encodes each
// one into a 32-bit word and writes it to consecutive instruction memory words.
// Each command takes three cycles: accept (IDLE), encode (ENC), write (WR).
module instr_encoder_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_rs,
    input  logic [4:0]  cmd_rt,
    input  logic [4:0]  cmd_rd,
    input  logic [5:0]  cmd_funct,
    input  logic [15:0] cmd_imm,
    input  logic [25:0] cmd_target,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [8:0]  word_count,
    output logic        full,
    output logic        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ENC  = 2'd1;
    localparam logic [1:0] WR   = 2'd2;

    localparam logic [8:0] DEPTH_CNT = 9'(DEPTH);

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  rd_q, rd_d;
    logic [5:0]  funct_q, funct_d;
    logic [15:0] imm_q, imm_d;
    logic [25:0] target_q, target_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [8:0]  count_q, count_d;
    logic        err_q, err_d;

    logic        accept;
    logic        op_valid;
    logic [31:0] enc_word;

    assign full       = (count_q == DEPTH_CNT);
    assign cmd_ready  = (state_q == IDLE) && !full && !clr && !rst;
    assign mem_we     = (state_q == WR) && !clr && !rst;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign word_count = count_q;
    assign err        = err_q;

    assign accept   = cmd_valid && cmd_ready;
    assign op_valid = (op_q <= 3'd5);

    // Encode the latched command fields into an instruction word.
    always_comb begin
        enc_word = '0;
        case (op_q)
            3'd0:    enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, funct_q};
            3'd1:    enc_word = {6'b100011, rs_q, rt_q, imm_q};
            3'd2:    enc_word = {6'b101011, rs_q, rt_q, imm_q};
            3'd3:    enc_word = {6'b000100, rs_q, rt_q, imm_q};
            3'd4:    enc_word = {6'b001000, rs_q, rt_q, imm_q};
            3'd5:    enc_word = {6'b000010, target_q};
            default: enc_word = '0;
        endcase
    end

    // Next-state logic: accept, encode/validate, write; clr overrides everything.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        funct_d  = funct_q;
        imm_d    = imm_q;
        target_d = target_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        count_d  = count_q;
        err_d    = err_q;
        if (clr) begin
            state_d = IDLE;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_d     = cmd_op;
                        rs_d     = cmd_rs;
                        rt_d     = cmd_rt;
                        rd_d     = cmd_rd;
                        funct_d  = cmd_funct;
                        imm_d    = cmd_imm;
                        target_d = cmd_target;
                        state_d  = ENC;
                    end
                end
                ENC: begin
                    if (op_valid) begin
                        wdata_d = enc_word;
                        addr_d  = BASE_ADDR + {21'b0, count_q, 2'b00};
                        state_d = WR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                WR: begin
                    count_d = count_q + 9'd1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            funct_q  <= '0;
            imm_q    <= '0;
            target_q <= '0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            funct_q  <= funct_d;
            imm_q    <= imm_d;
            target_q <= target_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: scoreboard of expected writes, filled
// when a command is driven and drained by a write monitor on the falling edge.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst, clr, cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [5:0]  cmd_funct;
    logic [15:0] cmd_imm;
    logic [25:0] cmd_target;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [8:0]  word_count;
    logic        full, err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned mcount   = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    instr_encoder_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_funct(cmd_funct), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_count(word_count), .full(full), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_we", {31'b0, mem_we}, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("wr_addr", mem_addr, e[63:32]);
                check("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic scramble();
        cmd_op     = 3'($urandom);
        cmd_rs     = 5'($urandom);
        cmd_rt     = 5'($urandom);
        cmd_rd     = 5'($urandom);
        cmd_funct  = 6'($urandom);
        cmd_imm    = 16'($urandom);
        cmd_target = 26'($urandom);
    endtask

    // Wait (bounded) for ready, present a command for one accept edge.
    task automatic present(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [5:0] funct,
                           input logic [15:0] imm, input logic [25:0] target);
        int unsigned t;
        t = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", {31'b0, cmd_ready}, 32'd1);
        cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        cmd_funct = funct; cmd_imm = imm; cmd_target = target;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        scramble();
    endtask

    // Full command with cycle-exact timing checks.
    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] funct,
                        input logic [15:0] imm, input logic [25:0] target,
                        input logic [31:0] exp_word);
        if (op <= 3'd5) sb.push_back({32'(mcount * 4), exp_word});
        present(op, rs, rt, rd, funct, imm, target);
        @(negedge clk);
        check("ready_enc", {31'b0, cmd_ready}, 32'd0);
        check("we_enc", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        if (op <= 3'd5) begin
            check("we_wr", {31'b0, mem_we}, 32'd1);
            check("ready_wr", {31'b0, cmd_ready}, 32'd0);
            mcount++;
            @(negedge clk);
            check("ready_after", {31'b0, cmd_ready}, (mcount != 4) ? 32'd1 : 32'd0);
            check("count", {23'b0, word_count}, mcount);
        end else begin
            check("we_inv", {31'b0, mem_we}, 32'd0);
            check("err_set", {31'b0, err}, 32'd1);
            check("ready_inv", {31'b0, cmd_ready}, 32'd1);
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("ready_clr", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        mcount = 0;
        check("count_clr", {23'b0, word_count}, 32'd0);
        check("err_clr", {31'b0, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", n_checks, 0);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; cmd_valid = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_rst", {31'b0, cmd_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_count", {23'b0, word_count}, 32'd0);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_ready", {31'b0, cmd_ready}, 32'd1);

        // ADDI after reset
        send(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005, 26'd0, 32'h2008_0005);

        // R_TYPE then J
        do_clr();
        send(3'd0, 5'd9, 5'd10, 5'd8, 6'h20, 16'd0, 26'd0, 32'h012A_4020);
        send(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0010, 32'h0800_0010);

        // invalid op then LW; err sticks
        do_clr();
        send(3'd7, 5'd1, 5'd2, 5'd3, 6'd4, 16'h1234, 26'd5, 32'h0);
        send(3'd1, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0, 32'h8FA8_0004);
        check("err_sticky", {31'b0, err}, 32'd1);

        // fill to DEPTH=4, fifth command must never be accepted
        do_clr();
        for (int i = 0; i < 4; i++)
            send(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'(i + 1), 26'd0, 32'h2008_0000 + 32'(i + 1));
        check("full_set", {31'b0, full}, 32'd1);
        cmd_op = 3'd4; cmd_rs = 5'd0; cmd_rt = 5'd8; cmd_imm = 16'h00AA;
        cmd_valid = 1'b1;
        begin
            int unsigned rdy;
            rdy = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (cmd_ready === 1'b1) rdy++;
            end
            check("ready_while_full", rdy, 32'd0);
        end
        cmd_valid = 1'b0;
        check("count_no_wrap", {23'b0, word_count}, 32'd4);

        // clr during WR of the third command (err set beforehand)
        do_clr();
        send(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'h0);
        send(3'd2, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0, 32'hAC64_0010);
        send(3'd1, 5'd5, 5'd6, 5'd0, 6'd0, 16'h0020, 26'd0, 32'h8CA6_0020);
        present(3'd4, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        check("we_clr_wr", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        mcount = 0;
        check("count_after_clr", {23'b0, word_count}, 32'd0);
        check("err_after_clr", {31'b0, err}, 32'd0);
        send(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0007, 26'd0, 32'h2008_0007);

        // rst during ENC aborts the write
        present(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FF_FFFF);
        rst = 1'b1;
        @(negedge clk);
        check("ready_rst_enc", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mcount = 0;
        @(negedge clk);
        check("rst2_we", {31'b0, mem_we}, 32'd0);
        check("rst2_addr", mem_addr, 32'h0);
        check("rst2_wdata", mem_wdata, 32'h0);
        check("rst2_count", {23'b0, word_count}, 32'd0);
        check("rst2_err", {31'b0, err}, 32'd0);
        repeat (2) @(negedge clk);
        send(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 32'h1022_FFFF);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256: instruction memory capacity in words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port clr, input, 1: restart loading at BASE_ADDR and clear count and err.
REQ-006 SHALL have port cmd_valid, input, 1: a command is presented.
REQ-007 SHALL have port cmd_ready, output, 1: the block can accept a command.
REQ-008 SHALL have port cmd_op, input, 3: 0=R_TYPE, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J, 6-7 invalid.
REQ-009 SHALL have ports cmd_rs, cmd_rt, cmd_rd, input, 5 each: register fields.
REQ-010 SHALL have port cmd_funct, input, 6: R_TYPE function field.
REQ-011 SHALL have port cmd_imm, input, 16: immediate or offset field.
REQ-012 SHALL have port cmd_target, input, 26: J target field.
REQ-013 SHALL have port mem_we, output, 1: instruction memory write strobe.
REQ-014 SHALL have port mem_addr, output, 32: byte address of the write.
REQ-015 SHALL have port mem_wdata, output, 32: encoded instruction word.
REQ-016 SHALL have port word_count, output, 9: number of words written since reset or clr.
REQ-017 SHALL have port full, output, 1: word_count equals DEPTH.
REQ-018 SHALL have port err, output, 1: sticky flag set by an invalid cmd_op.

Function
REQ-019 SHALL implement FSM states IDLE, ENC and WR.
REQ-020 SHALL drive cmd_ready=1 only when in IDLE, full=0 and clr=0.
REQ-021 SHALL treat a command as accepted on a cycle where cmd_valid and cmd_ready are both 1; on accept, latch all cmd_* fields and go IDLE->ENC.
REQ-022 SHALL, in ENC, register the encoded word and go to WR when cmd_op is valid.
REQ-023 SHALL, in ENC, set err, write nothing and return to IDLE when cmd_op is invalid (6-7).
REQ-024 SHALL encode R_TYPE as {6'b000000, rs, rt, rd, 5'b00000, funct}.
REQ-025 SHALL encode LW as {6'b100011, rs, rt, imm}, SW as {6'b101011, rs, rt, imm}, BEQ as {6'b000100, rs, rt, imm} and ADDI as {6'b001000, rs, rt, imm}.
REQ-026 SHALL encode J as {6'b000010, target}.
REQ-027 SHALL, in WR, assert mem_we for exactly one cycle, with mem_addr = BASE_ADDR + 4*word_count and mem_wdata = the encoded word.
REQ-028 SHALL increment word_count at the end of the WR cycle and return to IDLE.
REQ-029 SHALL give fixed timing: accept at cycle N, mem_we at cycle N+2, cmd_ready high again at cycle N+3; maximum throughput is one command per 3 cycles.
REQ-030 SHALL hold mem_we=0 outside WR; mem_addr and mem_wdata may keep their last value but SHALL be stable and valid whenever mem_we=1.
REQ-031 SHALL assert full when word_count==DEPTH; while full, cmd_valid is ignored, no write occurs and word_count does not wrap.
REQ-032 SHALL, when clr=1 in any state, return to IDLE on the next edge with word_count=0, err=0 and no write; an in-flight command is discarded even if clr coincides with WR, and clr takes priority over mem_we.
REQ-033 SHALL ignore cmd_* input changes after accept; the latched values are used.
REQ-034 SHALL keep err set across later valid commands, which still encode and write normally; only clr or rst clear err.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, enter IDLE with mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, full=0, err=0 and cmd_ready=0 during the reset cycle.
REQ-036 SHALL give rst priority over clr and over any command, including reset asserted in ENC or WR, which aborts the write.

Verification
REQ-037 Scenario: after reset, ADDI rs=0, rt=8, imm=16'h0005 -> mem_we at accept+2, mem_addr=0x0, mem_wdata=0x20080005, word_count=1.
REQ-038 Scenario: R_TYPE rs=9, rt=10, rd=8, funct=0x20, then J target=0x0000010 -> writes 0x012A4020 @0x0 and 0x08000010 @0x4; cmd_ready low for 2 cycles after each accept.
REQ-039 Scenario: cmd_op=7, then LW rs=29, rt=8, imm=0x0004 -> first command writes nothing and sets err=1; then 0x8FA80004 @0x0 with err still 1.
REQ-040 Scenario: DEPTH=4, issue 5 valid commands -> 4 writes at 0x0, 0x4, 0x8, 0xC; full=1, cmd_ready=0 and the 5th command is never accepted.
REQ-041 Scenario: clr asserted during WR of the third command -> no mem_we that cycle; word_count=0, err=0, and the next command writes to BASE_ADDR.
REQ-042 Scenario: rst asserted during ENC -> no write, all outputs at reset values, and a later BEQ rs=1, rt=2, imm=0xFFFF writes 0x1022FFFF @0x0.
